// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, layer geometry and layer-to-width lookup for the 3x3 convolution PE
package conv_pkg;
    localparam int WT_W    = 8;
    localparam int PX_W    = 16;
    localparam int ACC_W   = 28;
    localparam int SHIFT   = 8;
    localparam int OUT_W   = 16;
    localparam int PROD_W  = WT_W + PX_W;
    localparam int CNT_W   = 5;
    localparam int W_L0    = 26;
    localparam int W_L1    = 12;
    localparam int W_L2    = 5;
    localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1 << (SHIFT - 1));

    function automatic logic [CNT_W-1:0] layer_w(input logic [1:0] layer);
        return layer == 2'd1 ? CNT_W'(W_L1) : layer == 2'd2 ? CNT_W'(W_L2) : CNT_W'(W_L0);
    endfunction
endpackage

// File: rtl/conv3_mac_tree.sv
// conv3_mac_tree: registered 9-way signed products (S1) and their registered sum (S2), flushable
module conv3_mac_tree
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [3*WT_W-1:0]       weight_0,
    input  logic [3*WT_W-1:0]       weight_1,
    input  logic [3*WT_W-1:0]       weight_2,
    input  logic [3*PX_W-1:0]       data_0,
    input  logic [3*PX_W-1:0]       data_1,
    input  logic [3*PX_W-1:0]       data_2,
    output logic                    sum_valid,
    output logic signed [ACC_W-1:0] sum
);
    logic [3*WT_W-1:0] w_rows [3];
    logic [3*PX_W-1:0] d_rows [3];
    logic signed [PROD_W-1:0] prod [9];
    logic signed [ACC_W-1:0] tree_sum;
    logic prod_valid;

    assign w_rows = '{weight_0, weight_1, weight_2};
    assign d_rows = '{data_0, data_1, data_2};

    // Weights are sampled here together with their window, so later weight changes never reach it
    always_ff @(posedge clk)
        if (in_valid)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    prod[3*i+j] <= $signed(w_rows[i][WT_W*j +: WT_W]) * $signed(d_rows[i][PX_W*j +: PX_W]);

    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < 9; k++)
            tree_sum = tree_sum + ACC_W'(prod[k]);
    end

    always_ff @(posedge clk)
        if (prod_valid)
            sum <= tree_sum;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            prod_valid <= 1'b0;
            sum_valid  <= 1'b0;
        end else if (flush) begin
            prod_valid <= 1'b0;
            sum_valid  <= 1'b0;
        end else begin
            prod_valid <= in_valid;
            sum_valid  <= prod_valid;
        end
endmodule

// File: rtl/conv3x3_pe.sv
// conv3x3_pe: raster-tracked 3x3 signed convolution with round, shift, ReLU and saturation
module conv3x3_pe
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        layer_num,
    input  logic              i_start,
    input  logic              i_valid,
    input  logic [3*WT_W-1:0] i_weight_0,
    input  logic [3*WT_W-1:0] i_weight_1,
    input  logic [3*WT_W-1:0] i_weight_2,
    input  logic [3*PX_W-1:0] i_data_0,
    input  logic [3*PX_W-1:0] i_data_1,
    input  logic [3*PX_W-1:0] i_data_2,
    output logic              o_valid,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_done,
    output logic              o_busy
);
    localparam logic signed [ACC_W-SHIFT-1:0] R_MAX = (ACC_W-SHIFT)'(OUT_MAX);

    logic [CNT_W-1:0] w, col, row;
    logic [2:0] last_pipe;
    logic take, win, col_end, sum_valid;
    logic signed [ACC_W-1:0] sum, rounded;
    logic signed [ACC_W-SHIFT-1:0] r;
    logic [OUT_W-1:0] sat;

    // row reaching w means the final window was taken; further pixels are dropped
    assign col_end = col == w - 1'b1;
    assign take    = o_busy && i_valid && !i_start && row != w;
    assign win     = take && col >= CNT_W'(2) && row >= CNT_W'(2);
    assign rounded = sum + RND;
    assign r       = rounded[ACC_W-1:SHIFT];
    assign sat     = r[ACC_W-SHIFT-1] ? '0 : r > R_MAX ? OUT_W'(OUT_MAX) : r[OUT_W-1:0];

    conv3_mac_tree u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (i_start),
        .in_valid  (win),
        .weight_0  (i_weight_0),
        .weight_1  (i_weight_1),
        .weight_2  (i_weight_2),
        .data_0    (i_data_0),
        .data_1    (i_data_1),
        .data_2    (i_data_2),
        .sum_valid (sum_valid),
        .sum       (sum)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            w         <= CNT_W'(W_L0);
            col       <= '0;
            row       <= '0;
            last_pipe <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_valid   <= 1'b0;
            o_data    <= '0;
        end else if (i_start) begin
            w         <= layer_w(layer_num);
            col       <= '0;
            row       <= '0;
            last_pipe <= '0;
            o_busy    <= 1'b1;
            o_done    <= 1'b0;
            o_valid   <= 1'b0;
        end else begin
            if (take) begin
                col <= col_end ? '0 : col + 1'b1;
                row <= col_end ? row + 1'b1 : row;
            end
            // tags the final window so o_done lands one cycle after its result
            last_pipe <= {last_pipe[1:0], win && col_end && row == w - 1'b1};
            o_valid   <= sum_valid;
            o_data    <= sum_valid ? sat : o_data;
            o_done    <= last_pipe[2];
            o_busy    <= last_pipe[2] ? 1'b0 : o_busy;
        end
endmodule

// File: tb/tb_conv3x3_pe.sv
// tb_conv3x3_pe: table vectors and random layers against an index-arithmetic convolution model
module tb_conv3x3_pe;
    typedef struct {
        logic [1:0]         layer;
        logic signed [7:0]  w_all;
        logic signed [7:0]  w_c;
        logic signed [15:0] p_all;
        logic signed [15:0] p_c;
        int                 exp;
    } vec_t;
    typedef struct { int due; int val; } ent_t;

    logic clk = 0, rst_n = 0, i_start = 0, i_valid = 0;
    logic [1:0] layer_num = 0;
    logic [23:0] wt [3];
    logic [47:0] px [3];
    logic o_valid, o_done, o_busy;
    logic [15:0] o_data;

    int n_cmp = 0, n_bad = 0, cyc = 0, n_res = 0, n_done = 0, last_data = 0;
    int exp_done = -1, idx = 0, w_m = 26;
    bit active = 0;
    ent_t q[$];
    vec_t tbl [11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    conv3x3_pe dut (
        .clk(clk), .rst_n(rst_n), .layer_num(layer_num), .i_start(i_start), .i_valid(i_valid),
        .i_weight_0(wt[0]), .i_weight_1(wt[1]), .i_weight_2(wt[2]),
        .i_data_0(px[0]), .i_data_1(px[1]), .i_data_2(px[2]),
        .o_valid(o_valid), .o_data(o_data), .o_done(o_done), .o_busy(o_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int wof(input logic [1:0] ln);
        return ln == 2'd1 ? 12 : ln == 2'd2 ? 5 : 26;
    endfunction

    function automatic int ref_out();
        int s = 0, r;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'($signed(wt[i][8*j +: 8])) * int'($signed(px[i][16*j +: 16]));
        r = (s + 128) >>> 8;
        return r < 0 ? 0 : r > 32767 ? 32767 : r;
    endfunction

    // One clock of stimulus; the model decides window position from the accepted-pixel index
    task automatic tick(input bit v, input bit st, input logic [1:0] ln);
        i_valid = v; i_start = st; layer_num = ln;
        if (st) begin
            active = 1; w_m = wof(ln); idx = 0;
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
            if (exp_done > cyc) exp_done = -1;
        end else if (v && active && idx < w_m * w_m) begin
            if (idx % w_m >= 2 && idx / w_m >= 2) begin
                q.push_back('{cyc + 3, ref_out()});
                if (idx == w_m * w_m - 1) exp_done = cyc + 4;
            end
            idx++;
        end
        @(posedge clk); #1;
        i_valid = 0; i_start = 0;
    endtask

    task automatic rnd_inputs();
        for (int i = 0; i < 3; i++) begin
            wt[i] = 24'($urandom);
            px[i] = {16'($urandom), 32'($urandom)};
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                wt[i][8*j +: 8]   = (i == 1 && j == 1) ? v.w_c : v.w_all;
                px[i][16*j +: 16] = (i == 1 && j == 1) ? v.p_c : v.p_all;
            end
    endtask

    task automatic wait_done();
        int g = 0;
        while ((q.size() > 0 || cyc <= exp_done) && g < 300) begin
            tick(0, 0, layer_num);
            g++;
        end
        chk("drain_timeout", int'(g >= 300), 0);
    endtask

    task automatic restart(input logic [1:0] ln, input bit v);
        tick(v, 1, ln);
        n_res = 0; n_done = 0;
        chk("busy_after_start", o_busy, 1);
    endtask

    always @(negedge clk) begin
        bit ev;
        if (rst_n) begin
            ev = q.size() > 0 && q[0].due == cyc;
            if (o_valid || ev) begin
                chk("o_valid", o_valid, ev);
                if (ev) begin
                    chk("o_data", o_data, q[0].val);
                    void'(q.pop_front());
                end
            end
            if (o_valid) begin n_res++; last_data = o_data; end
            if (o_done || cyc == exp_done) chk("o_done", o_done, cyc == exp_done);
            if (o_done) n_done++;
        end
    end

    initial begin
        tbl[0]  = '{2'd2, 8'sd1,    8'sd1,    16'sd256,   16'sd256,   9};
        tbl[1]  = '{2'd2, 8'sd0,    8'sd2,    16'sd0,     -16'sd1000, 0};
        tbl[2]  = '{2'd1, 8'sd127,  8'sd127,  16'sd32767, 16'sd32767, 32767};
        tbl[3]  = '{2'd2, 8'sd0,    8'sd1,    16'sd0,     16'sd128,   1};
        tbl[4]  = '{2'd2, 8'sd0,    8'sd1,    16'sd0,     16'sd127,   0};
        tbl[5]  = '{2'd2, 8'sd0,    8'sd1,    16'sd0,     16'sd383,   1};
        tbl[6]  = '{2'd2, 8'sd0,    8'sd1,    16'sd0,     16'sd384,   2};
        tbl[7]  = '{2'd2, 8'sd0,    -8'sd1,   16'sd0,     16'sd129,   0};
        tbl[8]  = '{2'd3, -8'sd1,   -8'sd1,   -16'sd100,  -16'sd100,  4};
        tbl[9]  = '{2'd2, -8'sd128, -8'sd128, -16'sd32768, -16'sd32768, 32767};
        tbl[10] = '{2'd2, 8'sd3,    -8'sd5,   16'sd1000,  16'sd2000,  55};
        for (int i = 0; i < 3; i++) begin wt[i] = '0; px[i] = '0; end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", o_valid, 0);
        chk("reset_data", o_data, 0);
        chk("reset_done", o_done, 0);
        chk("reset_busy", o_busy, 0);
        rst_n = 1;
        tick(0, 0, 0);

        for (int t = 0; t < 11; t++) begin
            int w;
            load(tbl[t]);
            restart(tbl[t].layer, 0);
            w = wof(tbl[t].layer);
            for (int k = 0; k < w * w; k++) tick(1, 0, 2'($urandom));
            wait_done();
            chk("tbl_results", n_res, (w - 2) * (w - 2));
            chk("tbl_value", last_data, tbl[t].exp);
            chk("tbl_done_pulses", n_done, 1);
            chk("tbl_busy_end", o_busy, 0);
        end

        restart(2'd0, 0);
        for (int k = 0; k < 676; k++) begin
            while ($urandom_range(3) == 0) tick(0, 0, 2'($urandom));
            rnd_inputs();
            tick(1, 0, 2'($urandom));
        end
        repeat (5) begin rnd_inputs(); tick(1, 0, 2'($urandom)); end
        wait_done();
        chk("l0_results", n_res, 576);
        chk("l0_done_pulses", n_done, 1);

        restart(2'd0, 0);
        begin
            int g = 0;
            while (n_res < 10 && g < 1000) begin rnd_inputs(); tick(1, 0, 2'd0); g++; end
            chk("pre_abort_timeout", int'(g >= 1000), 0);
        end
        rnd_inputs();
        restart(2'd2, 1);
        for (int k = 0; k < 25; k++) begin rnd_inputs(); tick(1, 0, 2'($urandom)); end
        wait_done();
        chk("abort_results", n_res, 9);
        chk("abort_done_pulses", n_done, 1);

        restart(2'd2, 0);
        for (int k = 0; k < 15; k++) begin rnd_inputs(); tick(1, 0, 2'd2); end
        rst_n = 0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_data", o_data, 0);
        chk("midrst_done", o_done, 0);
        chk("midrst_busy", o_busy, 0);
        active = 0; q.delete(); exp_done = -1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        n_res = 0; n_done = 0;
        repeat (8) begin rnd_inputs(); tick(1, 0, 2'd2); end
        chk("post_rst_results", n_res, 0);
        chk("post_rst_done", n_done, 0);
        chk("post_rst_busy", o_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
